// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
// Serialises GRB pixel words MSB first into the WS2812 one-wire waveform.
// Every bit is a high phase followed by a low phase, both counted in
// CLK_Enable ticks. Back-to-back pixels run with zero gap, and a frame
// closes with a reset-low latch period.
// Build option: define WS2812_RGBW_EN for 32-bit SK6812 {G,R,B,W} words;
// otherwise the words are 24-bit {G,R,B}.
module ws2812_bit_encoder #(
    parameter int T0H     = 20,
    parameter int T0L     = 43,
    parameter int T1H     = 40,
    parameter int T1L     = 23,
    parameter int RES_CYC = 2500,
    parameter int CNT_W   = 12,
`ifdef WS2812_RGBW_EN
    localparam int DATA_W = 32
`else
    localparam int DATA_W = 24
`endif
) (
    input  logic              Clock,
    input  logic              cRst,
    input  logic              CLK_Enable,
    input  logic [DATA_W-1:0] PixelData,
    input  logic              PixelLast,
    input  logic              PixelValid,
    output logic              PixelReady,
    output logic              DOut,
    output logic              Busy,
    output logic              FrameDone,
    output logic              Underrun
);

    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   shreg;
    logic                last_q;
    logic                dout_q;
    logic                frame_done_q;
    logic                underrun_q;
    logic                xfer;
    logic                word_end;

    // Reload value for the high phase of a bit (count runs down to zero).
    function automatic logic [CNT_W-1:0] high_len(input logic b);
        return b ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
    endfunction

    // Reload value for the low phase of a bit.
    function automatic logic [CNT_W-1:0] low_len(input logic b);
        return b ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
    endfunction

    // Final tick of bit 0's low phase: the only moment a follow-on word can be taken mid-frame.
    assign word_end   = (state == LOW) && CLK_Enable && (cnt == '0) && (idx == '0);
    assign PixelReady = (state == IDLE) || (word_end && !last_q);
    assign xfer       = PixelValid && PixelReady;

    assign DOut      = dout_q;
    assign Busy      = (state != IDLE);
    assign FrameDone = frame_done_q;
    assign Underrun  = underrun_q;

    // Bit-phase FSM: loads words, times high/low phases per tick, drives the line and status pulses.
    always_ff @(posedge Clock) begin
        if (cRst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            last_q       <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg  <= PixelData;
                        last_q <= PixelLast;
                        idx    <= IDX_W'(DATA_W - 1);
                        cnt    <= high_len(PixelData[DATA_W-1]);
                        dout_q <= 1'b1;
                        state  <= HIGH;
                    end
                end
                HIGH: begin
                    if (CLK_Enable) begin
                        if (cnt == '0) begin
                            cnt    <= low_len(shreg[DATA_W-1]);
                            dout_q <= 1'b0;
                            state  <= LOW;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (CLK_Enable) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (idx != '0) begin
                            idx    <= idx - 1'b1;
                            shreg  <= shreg << 1;
                            cnt    <= high_len(shreg[DATA_W-2]);
                            dout_q <= 1'b1;
                            state  <= HIGH;
                        end else if (last_q) begin
                            cnt   <= CNT_W'(RES_CYC - 1);
                            state <= LATCH;
                        end else if (xfer) begin
                            shreg  <= PixelData;
                            last_q <= PixelLast;
                            idx    <= IDX_W'(DATA_W - 1);
                            cnt    <= high_len(PixelData[DATA_W-1]);
                            dout_q <= 1'b1;
                            state  <= HIGH;
                        end else begin
                            underrun_q <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                LATCH: begin
                    if (CLK_Enable) begin
                        if (cnt == '0) begin
                            frame_done_q <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
